ecc_apb_sequencer: RTL and testbench
====================================

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

Interface
REQ-001 Parameters SHALL be: AMBA_WORD, default 32, APB data width; AMBA_ADDR_WIDTH, default 20, APB address width; DATA_WIDTH, default 32, ECC data_out width; TIMEOUT_CYCLES, default 1024, maximum wait for operation_done.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. Ports are listed as name, direction, width, meaning:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a job is offered.
- req_ready  out  1  the sequencer accepts a job.
- req_operation  in  2  0 = encode, 1 = decode, 2 = full channel; 3 is illegal.
- req_code_width  in  2  code-width register value.
- req_data  in  AMBA_WORD  DATA_IN register value.
- req_noise  in  AMBA_WORD  NOISE register value.
- paddr  out  AMBA_ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  AMBA_WORD  APB write data.
- operation_done  in  1  ECC completion pulse.
- data_out  in  DATA_WIDTH  ECC result.
- num_of_errors  in  2  ECC error count.
- resp_valid  out  1  a result is offered.
- resp_ready  in  1  the consumer takes the result.
- resp_data  out  DATA_WIDTH  captured data_out.
- resp_num_errors  out  2  captured num_of_errors.
- resp_timeout  out  1  the job timed out.
- busy  out  1  the state is not IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, ACCESS, WAIT_DONE and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE.
- A job is accepted on any cycle with req_valid && req_ready.
- On acceptance, all req_* fields are registered and the write index is cleared to 0.
REQ-005 Write sequence, by index:
- Index 0: DATA_IN at address 0x04.
- Index 1: CODE_WIDTH at address 0x08, data = zero-extended req_code_width.
- Index 2: NOISE at address 0x0C.
- Index 3: CONTROL at address 0x00, data = zero-extended req_operation.
- CONTROL is always written last, because it starts the ECC operation.
REQ-006 SETUP SHALL drive psel=1, penable=0, pwrite=1, with paddr and pwdata per the index.
- ACCESS SHALL keep the same values with penable=1.
- Each write takes exactly 2 cycles; there is no wait-state input.
REQ-007 ACCESS transitions:
- Index < 3: go to SETUP with the index incremented.
- Index = 3: go to WAIT_DONE with the timeout counter cleared.
REQ-008 Outside SETUP and ACCESS, psel, penable and pwrite SHALL be 0.
- paddr and pwdata SHALL be 0 while idle.
REQ-009 WAIT_DONE, when operation_done=1:
- Capture data_out and num_of_errors.
- Set resp_timeout=0 and go to RESP.
- resp_valid is asserted the next cycle.
REQ-010 WAIT_DONE, when the counter reaches TIMEOUT_CYCLES-1 without operation_done:
- Go to RESP with resp_timeout=1, resp_data=0 and resp_num_errors=0.
- operation_done on the same cycle as expiry takes priority; that is a normal completion.
REQ-011 operation_done SHALL be ignored in every state other than WAIT_DONE.
REQ-012 RESP SHALL hold resp_valid=1 with stable outputs until resp_ready=1, then return to IDLE.
- A new job cannot be accepted in the same cycle as the resp_ready handshake; req_ready rises the following cycle.
REQ-013 A job with req_operation=3 SHALL be accepted and SHALL issue no APB traffic.
- It goes directly to RESP with resp_timeout=1 and zero data.
REQ-014 Latency: with acceptance at cycle 0, the writes occupy cycles 1–8 and WAIT_DONE begins at cycle 9.
- With operation_done seen at cycle N, resp_valid=1 at cycle N+1.
REQ-015 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL saturate rather than wrap.

Reset
REQ-016 reset=1 SHALL force, on the next edge:
- The state to IDLE.
- All outputs to 0, except req_ready=1.
- The counters and captured registers to 0.
REQ-017 A reset during an APB transfer SHALL drop psel and penable on the next edge with no completion phase; the in-flight job is discarded.

Structure
REQ-018 A shared package ecc_pkg SHALL hold:
- The state enum.
- The operation encodings.
- The register address constants ADDR_CONTROL, ADDR_DATA_IN, ADDR_CODE_WIDTH and ADDR_NOISE.
REQ-019 A sub-module ecc_timeout_counter, providing clear, enable and expired, SHALL implement REQ-015.
- All other logic stays in one FSM module.

Verification
REQ-020 Encode job:
- Stimulus: operation=0, data=0x0000_00A5, code_width=1, noise=0; operation_done pulses 5 cycles after the CONTROL write, with data_out=0x1234.
- Required response: APB writes 0x04=0xA5, 0x08=1, 0x0C=0, 0x00=0 in that order; resp_data=0x1234, resp_timeout=0.
REQ-021 Timeout:
- Stimulus: TIMEOUT_CYCLES=16 and no operation_done.
- Required response: resp_valid at WAIT_DONE entry + 16 cycles, with resp_timeout=1 and resp_data=0.
REQ-022 Back-pressure:
- Stimulus: resp_ready held low for 10 cycles.
- Required response: resp_valid and the data stay stable, and req_ready=0 throughout.
REQ-023 Stray done:
- Stimulus: operation_done pulsed during the NOISE write.
- Required response: it is ignored; the sequencer still waits in WAIT_DONE for a real pulse.
REQ-024 Reset during ACCESS of the CODE_WIDTH write:
- Required response: psel=0 the next cycle, the state returns to IDLE and req_ready=1.
REQ-025 Illegal operation:
- Stimulus: operation=3.
- Required response: no psel activity, and resp_timeout=1 within 2 cycles of acceptance.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared definitions for the ECC APB job sequencer:
//   - state_t          : sequencer FSM states
//   - OP_*             : operation encodings carried in req_operation / CONTROL
//   - ADDR_*           : ECC register map offsets
//   - reg_addr()       : register address for a given write index
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [1:0] OP_ENCODE  = 2'd0;
  localparam logic [1:0] OP_DECODE  = 2'd1;
  localparam logic [1:0] OP_FULL    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [7:0] ADDR_CONTROL    = 8'h00;
  localparam logic [7:0] ADDR_DATA_IN    = 8'h04;
  localparam logic [7:0] ADDR_CODE_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE      = 8'h0C;

  // CONTROL sits at the last index on purpose: writing it kicks off the
  // ECC operation, so every operand register must already be loaded.
  function automatic logic [7:0] reg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    reg_addr = ADDR_DATA_IN;
      2'd1:    reg_addr = ADDR_CODE_WIDTH;
      2'd2:    reg_addr = ADDR_NOISE;
      default: reg_addr = ADDR_CONTROL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_timeout_counter.sv
// ecc_timeout_counter
//   Saturating wait counter used while the sequencer waits for the ECC
//   engine to finish.
//   Ports:
//     clk     in  clock
//     reset   in  synchronous active-high reset
//     clear   in  restart the count from zero
//     enable  in  advance the count by one (holds at the last value)
//     expired out count has reached TIMEOUT_CYCLES-1
module ecc_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Saturates at LAST so a long stall can never wrap back to "not expired".
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer
//   Accepts one ECC job at a time, programs the ECC block over APB
//   (DATA_IN, CODE_WIDTH, NOISE, then CONTROL), waits for operation_done
//   with a timeout, and offers the captured result on a valid/ready port.
//   Ports:
//     clk, reset                         clock, synchronous active-high reset
//     req_valid/req_ready                job handshake
//     req_operation/code_width/data/noise job fields
//     paddr/psel/penable/pwrite/pwdata   APB master (writes only, no wait states)
//     operation_done/data_out/num_of_errors  ECC completion inputs
//     resp_valid/resp_ready              result handshake
//     resp_data/resp_num_errors/resp_timeout  captured result
//     busy                               sequencer not idle
module ecc_apb_sequencer
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_operation,
  input  logic [1:0]                 req_code_width,
  input  logic [AMBA_WORD-1:0]       req_data,
  input  logic [AMBA_WORD-1:0]       req_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [AMBA_WORD-1:0]       pwdata,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [1:0]                 resp_num_errors,
  output logic                       resp_timeout,
  output logic                       busy
);

  state_t                  state_reg, state_next;
  logic [1:0]              idx_reg, idx_next;
  logic [1:0]              op_reg, op_next;
  logic [1:0]              cw_reg, cw_next;
  logic [AMBA_WORD-1:0]    data_reg, data_next;
  logic [AMBA_WORD-1:0]    noise_reg, noise_next;
  logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;
  logic [1:0]              resp_nerr_reg, resp_nerr_next;
  logic                    resp_to_reg, resp_to_next;

  logic                    cnt_clear;
  logic                    cnt_enable;
  logic                    cnt_expired;
  logic [AMBA_WORD-1:0]    wr_data;

  ecc_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      op_reg        <= '0;
      cw_reg        <= '0;
      data_reg      <= '0;
      noise_reg     <= '0;
      resp_data_reg <= '0;
      resp_nerr_reg <= '0;
      resp_to_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      op_reg        <= op_next;
      cw_reg        <= cw_next;
      data_reg      <= data_next;
      noise_reg     <= noise_next;
      resp_data_reg <= resp_data_next;
      resp_nerr_reg <= resp_nerr_next;
      resp_to_reg   <= resp_to_next;
    end
  end

  // Write data for the current index; mirrors the order in reg_addr().
  always_comb begin
    case (idx_reg)
      2'd0:    wr_data = data_reg;
      2'd1:    wr_data = AMBA_WORD'(cw_reg);
      2'd2:    wr_data = noise_reg;
      default: wr_data = AMBA_WORD'(op_reg);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    op_next        = op_reg;
    cw_next        = cw_reg;
    data_next      = data_reg;
    noise_next     = noise_reg;
    resp_data_next = resp_data_reg;
    resp_nerr_next = resp_nerr_reg;
    resp_to_next   = resp_to_reg;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;
    req_ready      = 1'b0;
    psel           = 1'b0;
    penable        = 1'b0;
    pwrite         = 1'b0;
    paddr          = '0;
    pwdata         = '0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_next    = req_operation;
          cw_next    = req_code_width;
          data_next  = req_data;
          noise_next = req_noise;
          idx_next   = 2'd0;
          if (req_operation == OP_ILLEGAL) begin
            // Illegal jobs are answered immediately as a failed job so the
            // consumer always gets exactly one response per request.
            state_next     = ST_RESP;
            resp_to_next   = 1'b1;
            resp_data_next = '0;
            resp_nerr_next = '0;
          end else begin
            state_next = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        psel       = 1'b1;
        pwrite     = 1'b1;
        paddr      = AMBA_ADDR_WIDTH'(reg_addr(idx_reg));
        pwdata     = wr_data;
        state_next = ST_ACCESS;
      end

      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = AMBA_ADDR_WIDTH'(reg_addr(idx_reg));
        pwdata  = wr_data;
        if (idx_reg == 2'd3) begin
          state_next = ST_WAIT_DONE;
          cnt_clear  = 1'b1;
        end else begin
          idx_next   = idx_reg + 2'd1;
          state_next = ST_SETUP;
        end
      end

      ST_WAIT_DONE: begin
        cnt_enable = 1'b1;
        // operation_done wins over a simultaneous expiry.
        if (operation_done) begin
          resp_data_next = data_out;
          resp_nerr_next = num_of_errors;
          resp_to_next   = 1'b0;
          state_next     = ST_RESP;
        end else if (cnt_expired) begin
          resp_data_next = '0;
          resp_nerr_next = '0;
          resp_to_next   = 1'b1;
          state_next     = ST_RESP;
        end
      end

      ST_RESP: begin
        // req_ready stays low here, so a new job waits until IDLE.
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign resp_valid      = (state_reg == ST_RESP);
  assign resp_data       = resp_data_reg;
  assign resp_num_errors = resp_nerr_reg;
  assign resp_timeout    = resp_to_reg;
  assign busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer
//   Directed bench for ecc_apb_sequencer (TIMEOUT_CYCLES = 16). Inputs are
//   driven 1 ns after the rising edge and outputs are checked at that point;
//   an APB monitor logs completed writes on the falling edge.
module tb_ecc_apb_sequencer;

  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_operation;
  logic [1:0]     req_code_width;
  logic [AW-1:0]  req_data;
  logic [AW-1:0]  req_noise;
  logic [ADW-1:0] paddr;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [AW-1:0]  pwdata;
  logic           operation_done;
  logic [DW-1:0]  data_out;
  logic [1:0]     num_of_errors;
  logic           resp_valid;
  logic           resp_ready;
  logic [DW-1:0]  resp_data;
  logic [1:0]     resp_num_errors;
  logic           resp_timeout;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int psel_cycles = 0;
  int psel_snap;
  int base;
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];

  always #5 clk = ~clk;

  ecc_apb_sequencer #(
    .AMBA_WORD       (AW),
    .AMBA_ADDR_WIDTH (ADW),
    .DATA_WIDTH      (DW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_operation   (req_operation),
    .req_code_width  (req_code_width),
    .req_data        (req_data),
    .req_noise       (req_noise),
    .paddr           (paddr),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .pwdata          (pwdata),
    .operation_done  (operation_done),
    .data_out        (data_out),
    .num_of_errors   (num_of_errors),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_num_errors (resp_num_errors),
    .resp_timeout    (resp_timeout),
    .busy            (busy)
  );

  always @(negedge clk) begin
    if (psel) psel_cycles++;
    if (psel && penable && pwrite) begin
      wr_addr_log.push_back(32'(paddr));
      wr_data_log.push_back(pwdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input logic [1:0] op, input logic [1:0] cw,
                       input logic [31:0] d, input logic [31:0] nz);
    req_valid      = 1'b1;
    req_operation  = op;
    req_code_width = cw;
    req_data       = d;
    req_noise      = nz;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_operation  = 2'd0;
    req_code_width = 2'd0;
    req_data       = '0;
    req_noise      = '0;
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = 2'd0;
    resp_ready     = 1'b0;

    // ---------------- reset state ----------------
    tick_n(2);
    check("rst_req_ready",  32'(req_ready), 32'h1);
    check("rst_psel",       32'(psel), 32'h0);
    check("rst_penable",    32'(penable), 32'h0);
    check("rst_paddr",      32'(paddr), 32'h0);
    check("rst_pwdata",     pwdata, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data",  resp_data, 32'h0);
    check("rst_timeout",    32'(resp_timeout), 32'h0);
    check("rst_busy",       32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // ---------------- encode job ----------------
    base = wr_addr_log.size();
    offer(2'd0, 2'd1, 32'h0000_00A5, 32'h0);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    check("enc_c1_psel",    32'(psel), 32'h1);
    check("enc_c1_penable", 32'(penable), 32'h0);
    check("enc_c1_pwrite",  32'(pwrite), 32'h1);
    check("enc_c1_paddr",   32'(paddr), 32'h4);
    check("enc_c1_pwdata",  pwdata, 32'hA5);
    tick();                                   // cycle 2
    check("enc_c2_penable", 32'(penable), 32'h1);
    check("enc_c2_paddr",   32'(paddr), 32'h4);
    tick_n(6);                                // cycle 8
    check("enc_c8_paddr",   32'(paddr), 32'h0);
    check("enc_c8_penable", 32'(penable), 32'h1);
    tick();                                   // cycle 9: WAIT_DONE
    check("enc_c9_psel",    32'(psel), 32'h0);
    check("enc_c9_busy",    32'(busy), 32'h1);
    check("enc_nwrites",    32'(wr_addr_log.size() - base), 32'd4);
    check("enc_w0_addr",    wr_addr_log[base+0], 32'h04);
    check("enc_w0_data",    wr_data_log[base+0], 32'hA5);
    check("enc_w1_addr",    wr_addr_log[base+1], 32'h08);
    check("enc_w1_data",    wr_data_log[base+1], 32'h1);
    check("enc_w2_addr",    wr_addr_log[base+2], 32'h0C);
    check("enc_w2_data",    wr_data_log[base+2], 32'h0);
    check("enc_w3_addr",    wr_addr_log[base+3], 32'h00);
    check("enc_w3_data",    wr_data_log[base+3], 32'h0);
    tick_n(4);                                // cycle 13
    check("enc_c13_resp_valid", 32'(resp_valid), 32'h0);
    operation_done = 1'b1;
    data_out       = 32'h1234;
    num_of_errors  = 2'd2;
    tick();                                   // cycle 14
    operation_done = 1'b0;
    data_out       = 32'hDEAD;
    check("enc_resp_valid", 32'(resp_valid), 32'h1);
    check("enc_resp_data",  resp_data, 32'h1234);
    check("enc_resp_nerr",  32'(resp_num_errors), 32'h2);
    check("enc_resp_to",    32'(resp_timeout), 32'h0);
    check("enc_req_ready",  32'(req_ready), 32'h0);
    $display("job encode: resp_data=0x%0h nerr=%0d timeout=%0d", resp_data, resp_num_errors, resp_timeout);
    resp_ready = 1'b1;
    tick();                                   // back in IDLE
    resp_ready = 1'b0;
    check("enc_idle_resp_valid", 32'(resp_valid), 32'h0);
    check("enc_idle_req_ready",  32'(req_ready), 32'h1);

    // ---------------- timeout job ----------------
    offer(2'd2, 2'd0, 32'h11, 32'h22);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    data_out  = 32'hCAFE;
    tick_n(8);                                // cycle 9: WAIT_DONE entry
    tick_n(15);                               // cycle 24: last waiting cycle
    check("to_c24_resp_valid", 32'(resp_valid), 32'h0);
    check("to_c24_busy",       32'(busy), 32'h1);
    tick();                                   // cycle 25 = entry + 16
    check("to_resp_valid", 32'(resp_valid), 32'h1);
    check("to_resp_to",    32'(resp_timeout), 32'h1);
    check("to_resp_data",  resp_data, 32'h0);
    check("to_resp_nerr",  32'(resp_num_errors), 32'h0);
    $display("job timeout: resp_data=0x%0h nerr=%0d timeout=%0d", resp_data, resp_num_errors, resp_timeout);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // ---------------- done on the expiry cycle ----------------
    offer(2'd2, 2'd3, 32'h33, 32'h44);
    tick();
    req_valid = 1'b0;
    tick_n(8);                                // cycle 9
    tick_n(15);                               // cycle 24: counter expired
    operation_done = 1'b1;
    data_out       = 32'h77;
    num_of_errors  = 2'd1;
    tick();                                   // cycle 25
    operation_done = 1'b0;
    check("prio_resp_valid", 32'(resp_valid), 32'h1);
    check("prio_resp_to",    32'(resp_timeout), 32'h0);
    check("prio_resp_data",  resp_data, 32'h77);
    $display("job done-at-expiry: resp_data=0x%0h nerr=%0d timeout=%0d", resp_data, resp_num_errors, resp_timeout);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // ---------------- stray done + back-pressure ----------------
    offer(2'd1, 2'd2, 32'h55, 32'h3);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    tick_n(4);                                // cycle 5: NOISE setup
    check("stray_c5_paddr", 32'(paddr), 32'hC);
    operation_done = 1'b1;
    data_out       = 32'hBAD;
    num_of_errors  = 2'd3;
    tick();                                   // cycle 6: NOISE access
    check("stray_c6_paddr", 32'(paddr), 32'hC);
    tick();                                   // cycle 7: CONTROL setup
    operation_done = 1'b0;
    check("stray_c7_paddr",  32'(paddr), 32'h0);
    check("stray_c7_pwdata", pwdata, 32'h1);
    tick_n(5);                                // cycle 12
    check("stray_c12_resp_valid", 32'(resp_valid), 32'h0);
    check("stray_c12_busy",       32'(busy), 32'h1);
    operation_done = 1'b1;
    data_out       = 32'h0F0F;
    num_of_errors  = 2'd1;
    tick();                                   // cycle 13
    operation_done = 1'b0;
    data_out       = 32'h0;
    // Offer an illegal job while the response is stalled.
    offer(2'd3, 2'd0, 32'h99, 32'h98);
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'h1);
      check("bp_resp_data",  resp_data, 32'h0F0F);
      check("bp_resp_nerr",  32'(resp_num_errors), 32'h1);
      check("bp_req_ready",  32'(req_ready), 32'h0);
      tick();
    end
    $display("job decode (stalled): resp_data=0x%0h nerr=%0d timeout=%0d", resp_data, resp_num_errors, resp_timeout);
    resp_ready = 1'b1;
    check("bp_hs_req_ready", 32'(req_ready), 32'h0);
    tick();                                   // IDLE: illegal job accepted here
    resp_ready = 1'b0;
    base      = wr_addr_log.size();
    psel_snap = psel_cycles;
    check("hs_next_req_ready",  32'(req_ready), 32'h1);
    check("hs_next_resp_valid", 32'(resp_valid), 32'h0);

    // ---------------- illegal operation ----------------
    tick();                                   // acceptance + 1
    req_valid = 1'b0;
    check("ill_resp_valid", 32'(resp_valid), 32'h1);
    check("ill_resp_to",    32'(resp_timeout), 32'h1);
    check("ill_resp_data",  resp_data, 32'h0);
    check("ill_resp_nerr",  32'(resp_num_errors), 32'h0);
    check("ill_psel",       32'(psel), 32'h0);
    $display("job illegal: resp_data=0x%0h nerr=%0d timeout=%0d", resp_data, resp_num_errors, resp_timeout);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("ill_psel_cycles", 32'(psel_cycles - psel_snap), 32'h0);
    check("ill_nwrites",     32'(wr_addr_log.size() - base), 32'h0);

    // ---------------- reset during CODE_WIDTH access ----------------
    offer(2'd0, 2'd2, 32'h66, 32'h0);
    tick();                                   // cycle 1
    req_valid = 1'b0;
    tick_n(3);                                // cycle 4: CODE_WIDTH access
    check("rst_mid_paddr",   32'(paddr), 32'h8);
    check("rst_mid_penable", 32'(penable), 32'h1);
    reset = 1'b1;
    tick();
    check("rst_mid_psel",      32'(psel), 32'h0);
    check("rst_mid_penable2",  32'(penable), 32'h0);
    check("rst_mid_req_ready", 32'(req_ready), 32'h1);
    check("rst_mid_busy",      32'(busy), 32'h0);
    check("rst_mid_paddr2",    32'(paddr), 32'h0);
    reset = 1'b0;
    tick_n(2);
    check("rst_mid_idle_psel", 32'(psel), 32'h0);
    $display("job reset-mid-write: req_ready=%0d busy=%0d", req_ready, busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
